// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND display chain (scan controller,
// digit-position decoder and 7-segment encoder).
package fnd_pkg;

  localparam logic [3:0] FND_BLANK  = 4'hF;
  localparam int         FND_DIGITS = 4;
  localparam int         SEL_W      = 3;

  // Bits needed for a counter running 0..max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  // Leading-zero test: digit idx is suppressible when it and every higher digit are 0.
  function automatic logic lz_blank(input logic [15:0] value, input logic [1:0] idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int n = FND_DIGITS - 1; n >= 1; n--) begin
      if (n >= int'(idx)) all_zero &= (value[4*n +: 4] == 4'h0);
    end
    return (idx != 2'd0) && all_zero;
  endfunction

endpackage

// File: rtl/fnd_scan_if.sv
// Control/data bundle between the value producer and the FND scan controller.
interface fnd_scan_if;
  import fnd_pkg::*;

  logic             i_pwswitch;
  logic [15:0]      i_value;
  logic             i_update;
  logic [3:0]       i_dp_mask;
  logic             i_lz_en;
  logic             i_blink_en;
  logic [SEL_W-1:0] o_select;
  logic [3:0]       o_digit;
  logic             o_dp;
  logic             o_frame_done;

  modport master (
    output i_pwswitch, i_value, i_update, i_dp_mask, i_lz_en, i_blink_en,
    input  o_select, o_digit, o_dp, o_frame_done
  );

  modport slave (
    input  i_pwswitch, i_value, i_update, i_dp_mask, i_lz_en, i_blink_en,
    output o_select, o_digit, o_dp, o_frame_done
  );
endinterface

// File: rtl/fnd_scan_controller_tick_prescaler.sv
// Free-running 0..DIV-1 counter producing a one-cycle tick on its last count;
// a synchronous clear holds it at 0 and suppresses the tick.
module tick_prescaler
  import fnd_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/fnd_scan_controller.sv
// FND scan controller: steps the digit select, double-buffers the display value
// per frame and drives the select-aligned BCD digit / DP with LZ suppression and blink.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCAN_HZ    = 4_000,
  parameter int BLINK_HZ   = 2
) (
  input  logic      i_clk,
  input  logic      i_reset,
  fnd_scan_if.slave bus
);

  localparam int DIV = SYS_CLK_HZ / SCAN_HZ;
  localparam int HP  = SYS_CLK_HZ / (2 * BLINK_HZ);

  logic scan_tick, blink_tick, frame_bnd;
  logic [1:0] idx;
  logic [3:0] raw_digit;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [15:0]      pending_q, pending_d;
  logic [15:0]      active_q, active_d;
  logic             phase_q, phase_d;
  logic [3:0]       digit_q, digit_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  tick_prescaler #(.DIV(DIV)) u_scan_pre (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr_i  (bus.i_pwswitch),
    .tick_o (scan_tick)
  );

  tick_prescaler #(.DIV(HP)) u_blink_pre (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr_i  (1'b0),
    .tick_o (blink_tick)
  );

  always_comb begin
    sel_d     = sel_q;
    pending_d = pending_q;
    active_d  = active_q;
    phase_d   = phase_q ^ blink_tick;
    frame_d   = 1'b0;
    frame_bnd = scan_tick && (sel_q[1:0] == 2'd3);

    if (bus.i_update)        pending_d = bus.i_value;
    if (bus.i_pwswitch)      sel_d = '0;
    else if (scan_tick)      sel_d = sel_q + SEL_W'(1);
    // pending_d already carries a same-cycle strobe, so the newest value wins the reload.
    if (frame_bnd) begin
      active_d = pending_d;
      frame_d  = 1'b1;
    end

    // Output is computed from next-state select and buffer so data lands with its select.
    idx       = sel_d[1:0];
    raw_digit = active_d[{idx, 2'b00} +: 4];
    digit_d   = (bus.i_lz_en && lz_blank(active_d, idx)) ? FND_BLANK : raw_digit;
    dp_d      = bus.i_dp_mask[idx];

    if (bus.i_blink_en && phase_d) begin
      digit_d = FND_BLANK;
      dp_d    = 1'b0;
    end
    if (bus.i_pwswitch) begin
      digit_d = FND_BLANK;
      dp_d    = 1'b0;
      frame_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sel_q     <= '0;
      pending_q <= 16'hFFFF;
      active_q  <= 16'hFFFF;
      phase_q   <= 1'b0;
      digit_q   <= FND_BLANK;
      dp_q      <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      phase_q   <= phase_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.o_select     = sel_q;
  assign bus.o_digit      = digit_q;
  assign bus.o_dp         = dp_q;
  assign bus.o_frame_done = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with DIV=4 and blink half-period 20;
// k counts rising edges since the last reset release, samples taken on falling edges.
module tb_fnd_scan_controller;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   k     = 0;

  always #5 clk = ~clk;

  fnd_scan_if bus ();

  fnd_scan_controller #(
    .SYS_CLK_HZ (1000),
    .SCAN_HZ    (250),
    .BLINK_HZ   (25)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic go(input int t);
    if (t > k) step(t - k);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] sel, input logic [3:0] dig);
    check({tag, " sel"},   16'(bus.o_select), 16'(sel));
    check({tag, " digit"}, 16'(bus.o_digit),  16'(dig));
  endtask

  task automatic reset_and_load(input logic [15:0] v);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.i_value  = v;
    bus.i_update = 1'b1;
    k = 0;
    step(1);
    bus.i_update = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_pwswitch = 1'b0;
    bus.i_value    = 16'h0000;
    bus.i_update   = 1'b0;
    bus.i_dp_mask  = 4'b0000;
    bus.i_lz_en    = 1'b0;
    bus.i_blink_en = 1'b0;

    // Reset state
    @(negedge clk);
    chk_out("rst", 3'd0, 4'hF);
    check("rst dp", 16'(bus.o_dp), 16'd0);
    check("rst frame", 16'(bus.o_frame_done), 16'd0);
    check("rst pending", dut.pending_q, 16'hFFFF);
    check("rst active", dut.active_q, 16'hFFFF);

    // 1: first frame shows old active, then 1234 after boundary
    reset_and_load(16'h1234);
    go(3);  chk_out("t1 k3", 3'd0, 4'hF);
    go(4);  chk_out("t1 k4", 3'd1, 4'hF);
    go(15); check("t1 k15 frame", 16'(bus.o_frame_done), 16'd0);
    go(16); chk_out("t1 k16", 3'd4, 4'h4);
    check("t1 k16 frame", 16'(bus.o_frame_done), 16'd1);
    go(17); check("t1 k17 frame", 16'(bus.o_frame_done), 16'd0);
    go(20); chk_out("t1 k20", 3'd5, 4'h3);
    go(24); chk_out("t1 k24", 3'd6, 4'h2);
    go(28); chk_out("t1 k28", 3'd7, 4'h1);
    go(32); chk_out("t1 k32", 3'd0, 4'h4);
    check("t1 k32 frame", 16'(bus.o_frame_done), 16'd1);
    go(35); chk_out("t1 k35", 3'd0, 4'h4);
    go(36); chk_out("t1 k36", 3'd1, 4'h3);

    // 2: mid-frame update waits for boundary; boundary strobe shows at once
    bus.i_value = 16'h5678; bus.i_update = 1'b1;
    step(1); bus.i_update = 1'b0;
    go(40); chk_out("t2 k40", 3'd2, 4'h2);
    go(44); chk_out("t2 k44", 3'd3, 4'h1);
    go(48); chk_out("t2 k48", 3'd4, 4'h8);
    go(52); chk_out("t2 k52", 3'd5, 4'h7);
    go(56); chk_out("t2 k56", 3'd6, 4'h6);
    go(60); chk_out("t2 k60", 3'd7, 4'h5);
    go(63);
    bus.i_value = 16'h90A1; bus.i_update = 1'b1;
    step(1); bus.i_update = 1'b0;
    chk_out("t2 k64", 3'd0, 4'h1);
    check("t2 k64 frame", 16'(bus.o_frame_done), 16'd1);
    go(68); chk_out("t2 k68 nonbcd", 3'd1, 4'hA);

    // 3: leading-zero suppression
    bus.i_lz_en = 1'b1;
    reset_and_load(16'h0070);
    go(16); chk_out("t3 k16", 3'd4, 4'h0);
    go(20); chk_out("t3 k20", 3'd5, 4'h7);
    go(24); chk_out("t3 k24", 3'd6, 4'hF);
    go(28); chk_out("t3 k28", 3'd7, 4'hF);
    bus.i_value = 16'h0000; bus.i_update = 1'b1;
    step(1); bus.i_update = 1'b0;
    go(32); chk_out("t3 k32", 3'd0, 4'h0);
    go(36); chk_out("t3 k36", 3'd1, 4'hF);
    go(44); chk_out("t3 k44", 3'd3, 4'hF);
    bus.i_lz_en = 1'b0;
    step(1); chk_out("t3 k45 lz off", 3'd3, 4'h0);

    // 4: blink with DP mask on digit 2
    bus.i_blink_en = 1'b1;
    bus.i_dp_mask  = 4'b0100;
    reset_and_load(16'h1234);
    go(17); chk_out("t4 k17", 3'd4, 4'h4);
    check("t4 k17 dp", 16'(bus.o_dp), 16'd0);
    go(20); chk_out("t4 k20", 3'd5, 4'hF);
    go(24); chk_out("t4 k24", 3'd6, 4'hF);
    check("t4 k24 dp", 16'(bus.o_dp), 16'd0);
    go(39); chk_out("t4 k39", 3'd1, 4'hF);
    go(40); chk_out("t4 k40", 3'd2, 4'h2);
    check("t4 k40 dp", 16'(bus.o_dp), 16'd1);
    go(59); chk_out("t4 k59", 3'd6, 4'h2);
    check("t4 k59 dp", 16'(bus.o_dp), 16'd1);
    go(60); chk_out("t4 k60", 3'd7, 4'hF);
    check("t4 k60 dp", 16'(bus.o_dp), 16'd0);

    // 5: power switch freezes scan; pending still loads, active does not
    bus.i_blink_en = 1'b0;
    bus.i_dp_mask  = 4'b0000;
    reset_and_load(16'h1234);
    go(21); chk_out("t5 k21", 3'd5, 4'h3);
    bus.i_pwswitch = 1'b1;
    step(1); chk_out("t5 k22", 3'd0, 4'hF);
    check("t5 k22 frame", 16'(bus.o_frame_done), 16'd0);
    bus.i_value = 16'h5555; bus.i_update = 1'b1;
    step(1); bus.i_update = 1'b0;
    go(52); chk_out("t5 k52", 3'd0, 4'hF);
    bus.i_pwswitch = 1'b0;
    go(53); chk_out("t5 k53", 3'd0, 4'h4);
    go(55); chk_out("t5 k55", 3'd0, 4'h4);
    go(56); chk_out("t5 k56", 3'd1, 4'h3);
    go(68); chk_out("t5 k68", 3'd4, 4'h5);
    check("t5 k68 frame", 16'(bus.o_frame_done), 16'd1);

    // 6: asynchronous reset mid-cycle at select 6
    bus.i_dp_mask = 4'b0100;
    go(76); chk_out("t6 k76", 3'd6, 4'h5);
    check("t6 k76 dp", 16'(bus.o_dp), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk_out("t6 async", 3'd0, 4'hF);
    check("t6 async dp", 16'(bus.o_dp), 16'd0);
    check("t6 async frame", 16'(bus.o_frame_done), 16'd0);
    check("t6 async pending", dut.pending_q, 16'hFFFF);
    check("t6 async active", dut.active_q, 16'hFFFF);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
